// File: rtl/aq_ifu_btb_bank.sv
// Fully associative BTB bank: registered lookup, 2-bit direction counters, hit-or-allocate update, bulk invalidate.
// Optional build macro AQ_IFU_BTB_PARITY_EN adds per-entry even parity over {tag, target}.
module aq_ifu_btb_bank #(
  parameter int ENTRY_NUM = 8,
  parameter int TAG_WIDTH = 16,
  parameter int TGT_WIDTH = 16,
  parameter int PTR_WIDTH = 3
) (
  input  logic                 btb_entry_clk,
  input  logic                 cpurst_b,
  input  logic                 btb_rd_vld,
  input  logic [TAG_WIDTH-1:0] btb_rd_tag,
  output logic                 btb_rd_hit,
  output logic [TGT_WIDTH-1:0] btb_rd_tgt,
  output logic                 btb_rd_taken,
  output logic                 btb_rd_par_err,
  input  logic                 btb_upd_vld,
  input  logic [TAG_WIDTH-1:0] btb_upd_tag,
  input  logic [TGT_WIDTH-1:0] btb_upd_tgt,
  input  logic                 btb_upd_taken,
  input  logic                 btb_inv_all,
  output logic                 btb_upd_hit
);

  logic [ENTRY_NUM-1:0] entry_vld;
  logic [TAG_WIDTH-1:0] entry_tag [ENTRY_NUM];
  logic [TGT_WIDTH-1:0] entry_tgt [ENTRY_NUM];
  logic [1:0]           entry_cnt [ENTRY_NUM];
  logic [PTR_WIDTH-1:0] victim_ptr;

  logic [ENTRY_NUM-1:0] rd_match;
  logic [ENTRY_NUM-1:0] rd_good;
  logic [ENTRY_NUM-1:0] upd_match;
  logic [ENTRY_NUM-1:0] hit_we;
  logic [ENTRY_NUM-1:0] alloc_we;
  logic [ENTRY_NUM-1:0] par_clr;
  logic [TGT_WIDTH-1:0] rd_tgt_sel;
  logic                 rd_taken_sel;
  logic [PTR_WIDTH-1:0] free_idx;
  logic [PTR_WIDTH-1:0] alloc_idx;
  logic                 free_any;

  always_comb begin
    rd_match  = '0;
    upd_match = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      rd_match[i]  = entry_vld[i] && (entry_tag[i] == btb_rd_tag);
      upd_match[i] = entry_vld[i] && (entry_tag[i] == btb_upd_tag);
    end
  end

  assign btb_upd_hit = |upd_match;

  // Matches are one-hot, so OR-ing the gated fields selects the single hit entry.
  always_comb begin
    rd_tgt_sel   = '0;
    rd_taken_sel = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      rd_tgt_sel   = rd_tgt_sel | ({TGT_WIDTH{rd_good[i]}} & entry_tgt[i]);
      rd_taken_sel = rd_taken_sel | (rd_good[i] & entry_cnt[i][1]);
    end
  end

  // Lowest-index invalid entry wins; the round-robin pointer is only used when the bank is full.
  always_comb begin
    free_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!entry_vld[i]) begin
        free_idx = PTR_WIDTH'(i);
      end
    end
  end

  assign free_any  = ~(&entry_vld);
  assign alloc_idx = free_any ? free_idx : victim_ptr;

  always_comb begin
    alloc_we = '0;
    hit_we   = '0;
    if (btb_upd_vld && !btb_inv_all) begin
      if (btb_upd_hit) begin
        hit_we = upd_match;
      end else if (btb_upd_taken) begin
        alloc_we[alloc_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge btb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      entry_vld  <= '0;
      victim_ptr <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        entry_tag[i] <= '0;
        entry_tgt[i] <= '0;
        entry_cnt[i] <= '0;
      end
    end else if (btb_inv_all) begin
      entry_vld  <= '0;
      victim_ptr <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (alloc_we[i]) begin
          entry_vld[i] <= 1'b1;
          entry_tag[i] <= btb_upd_tag;
          entry_tgt[i] <= btb_upd_tgt;
          entry_cnt[i] <= 2'b10;
        end else begin
          if (par_clr[i]) begin
            entry_vld[i] <= 1'b0;
          end
          if (hit_we[i]) begin
            if (btb_upd_taken) begin
              entry_tgt[i] <= btb_upd_tgt;
              if (entry_cnt[i] != 2'b11) begin
                entry_cnt[i] <= entry_cnt[i] + 2'b01;
              end
            end else if (entry_cnt[i] != 2'b00) begin
              entry_cnt[i] <= entry_cnt[i] - 2'b01;
            end
          end
        end
      end
      if ((|alloc_we) && !free_any) begin
        victim_ptr <= victim_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge btb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      btb_rd_hit   <= 1'b0;
      btb_rd_taken <= 1'b0;
      btb_rd_tgt   <= '0;
    end else begin
      btb_rd_hit   <= btb_rd_vld & (|rd_good);
      btb_rd_taken <= btb_rd_vld & rd_taken_sel;
      if (btb_rd_vld) begin
        btb_rd_tgt <= rd_tgt_sel;
      end
    end
  end

`ifdef AQ_IFU_BTB_PARITY_EN
  logic [ENTRY_NUM-1:0] entry_par;
  logic [ENTRY_NUM-1:0] rd_bad;
  logic                 upd_par;

  assign upd_par = ^{btb_upd_tag, btb_upd_tgt};

  always_comb begin
    rd_good = '0;
    rd_bad  = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if ((^{entry_tag[i], entry_tgt[i]}) == entry_par[i]) begin
        rd_good[i] = rd_match[i];
      end else begin
        rd_bad[i] = rd_match[i];
      end
    end
  end

  // On a hit the stored tag equals the update tag, so one parity value covers both write cases.
  always_ff @(posedge btb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      entry_par <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (alloc_we[i] || (hit_we[i] && btb_upd_taken)) begin
          entry_par[i] <= upd_par;
        end
      end
    end
  end

  always_ff @(posedge btb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      btb_rd_par_err <= 1'b0;
      par_clr        <= '0;
    end else begin
      btb_rd_par_err <= btb_rd_vld & (|rd_bad);
      par_clr        <= btb_rd_vld ? rd_bad : '0;
    end
  end
`else
  assign rd_good        = rd_match;
  assign par_clr        = '0;
  assign btb_rd_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_aq_ifu_btb_bank.sv
// Scoreboard bench for aq_ifu_btb_bank: directed scenarios then random traffic against an array-based model.
module tb_aq_ifu_btb_bank;

  localparam int N  = 4;
  localparam int TW = 16;

  logic          btb_entry_clk;
  logic          cpurst_b;
  logic          btb_rd_vld;
  logic [TW-1:0] btb_rd_tag;
  logic          btb_rd_hit;
  logic [TW-1:0] btb_rd_tgt;
  logic          btb_rd_taken;
  logic          btb_rd_par_err;
  logic          btb_upd_vld;
  logic [TW-1:0] btb_upd_tag;
  logic [TW-1:0] btb_upd_tgt;
  logic          btb_upd_taken;
  logic          btb_inv_all;
  logic          btb_upd_hit;

  aq_ifu_btb_bank #(.ENTRY_NUM(N), .TAG_WIDTH(TW), .TGT_WIDTH(TW), .PTR_WIDTH(2)) dut (
    .btb_entry_clk (btb_entry_clk),
    .cpurst_b      (cpurst_b),
    .btb_rd_vld    (btb_rd_vld),
    .btb_rd_tag    (btb_rd_tag),
    .btb_rd_hit    (btb_rd_hit),
    .btb_rd_tgt    (btb_rd_tgt),
    .btb_rd_taken  (btb_rd_taken),
    .btb_rd_par_err(btb_rd_par_err),
    .btb_upd_vld   (btb_upd_vld),
    .btb_upd_tag   (btb_upd_tag),
    .btb_upd_tgt   (btb_upd_tgt),
    .btb_upd_taken (btb_upd_taken),
    .btb_inv_all   (btb_inv_all),
    .btb_upd_hit   (btb_upd_hit)
  );

  initial btb_entry_clk = 1'b0;
  always #5 btb_entry_clk = ~btb_entry_clk;

  typedef struct {
    int            due;
    logic          hit;
    logic [TW-1:0] tgt;
    logic          taken;
    logic          perr;
  } rd_exp_t;

  typedef struct {
    int   due;
    logic uhit;
  } uh_exp_t;

  rd_exp_t rd_q[$];
  uh_exp_t uh_q[$];
  int      cyc = 0;
  int      n_compared = 0;
  int      n_mismatch = 0;

  // Reference model: a plain table of entries plus a replacement pointer.
  bit            m_vld [N];
  logic [TW-1:0] m_tag [N];
  logic [TW-1:0] m_tgt [N];
  int            m_cnt [N];
  int            m_ptr;
  logic [TW-1:0] m_last_tgt;
  logic [TW-1:0] pool [6];

  always @(posedge btb_entry_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every registered response and the combinational hit flag that is due this cycle.
  always @(negedge btb_entry_clk) begin
    rd_exp_t r;
    uh_exp_t u;
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      r = rd_q.pop_front();
      checkOutput("rd_hit", 32'(btb_rd_hit), 32'(r.hit));
      checkOutput("rd_tgt", 32'(btb_rd_tgt), 32'(r.tgt));
      checkOutput("rd_taken", 32'(btb_rd_taken), 32'(r.taken));
      checkOutput("rd_par_err", 32'(btb_rd_par_err), 32'(r.perr));
    end
    if (uh_q.size() > 0 && uh_q[0].due == cyc) begin
      u = uh_q.pop_front();
      checkOutput("upd_hit", 32'(btb_upd_hit), 32'(u.uhit));
    end
  end

  function automatic int modelFind(input logic [TW-1:0] tag);
    for (int i = 0; i < N; i++) begin
      if (m_vld[i] && m_tag[i] == tag) return i;
    end
    return -1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      m_vld[i] = 1'b0;
      m_tag[i] = '0;
      m_tgt[i] = '0;
      m_cnt[i] = 0;
    end
    m_ptr      = 0;
    m_last_tgt = '0;
  endtask

  task automatic applyStimulus(input bit rd_vld, input logic [TW-1:0] rd_tag, input bit upd_vld,
                               input logic [TW-1:0] upd_tag, input logic [TW-1:0] upd_tgt,
                               input bit taken, input bit inv);
    rd_exp_t r;
    uh_exp_t u;
    int      idx;
    int      vic;
    @(posedge btb_entry_clk);
    #1;
    btb_rd_vld    = rd_vld;
    btb_rd_tag    = rd_tag;
    btb_upd_vld   = upd_vld;
    btb_upd_tag   = upd_tag;
    btb_upd_tgt   = upd_tgt;
    btb_upd_taken = taken;
    btb_inv_all   = inv;
    idx     = modelFind(rd_tag);
    r.due   = cyc + 1;
    r.perr  = 1'b0;
    r.hit   = rd_vld && (idx >= 0);
    r.taken = r.hit && (m_cnt[idx] >= 2);
    if (rd_vld) m_last_tgt = r.hit ? m_tgt[idx] : '0;
    r.tgt = m_last_tgt;
    rd_q.push_back(r);
    idx    = modelFind(upd_tag);
    u.due  = cyc;
    u.uhit = (idx >= 0);
    uh_q.push_back(u);
    if (inv) begin
      for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
      m_ptr = 0;
    end else if (upd_vld) begin
      if (idx >= 0) begin
        if (taken) begin
          m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
          m_tgt[idx] = upd_tgt;
        end else begin
          m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
        end
      end else if (taken) begin
        vic = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_vld[i]) vic = i;
        if (vic < 0) begin
          vic   = m_ptr;
          m_ptr = (m_ptr + 1) % N;
        end
        m_vld[vic] = 1'b1;
        m_tag[vic] = upd_tag;
        m_tgt[vic] = upd_tgt;
        m_cnt[vic] = 2;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Reset lands between edges, so the read just issued must never produce a response.
  task automatic applyReset();
    #2;
    cpurst_b = 1'b0;
    rd_q.delete();
    uh_q.delete();
    btb_rd_vld  = 1'b0;
    btb_upd_vld = 1'b0;
    btb_inv_all = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_hit", 32'(btb_rd_hit), 32'd0);
    checkOutput("rst_tgt", 32'(btb_rd_tgt), 32'd0);
    checkOutput("rst_taken", 32'(btb_rd_taken), 32'd0);
    checkOutput("rst_par_err", 32'(btb_rd_par_err), 32'd0);
    repeat (2) @(posedge btb_entry_clk);
    #3;
    cpurst_b = 1'b1;
    @(posedge btb_entry_clk);
    #1;
    checkOutput("post_rst_hit", 32'(btb_rd_hit), 32'd0);
    checkOutput("post_rst_tgt", 32'(btb_rd_tgt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cpurst_b      = 1'b0;
    btb_rd_vld    = 1'b0;
    btb_rd_tag    = '0;
    btb_upd_vld   = 1'b0;
    btb_upd_tag   = '0;
    btb_upd_tgt   = '0;
    btb_upd_taken = 1'b0;
    btb_inv_all   = 1'b0;
    modelReset();
    repeat (2) @(posedge btb_entry_clk);
    #3;
    cpurst_b = 1'b1;

    // Reset state: tag 0 is stored but invalid.
    applyStimulus(1'b1, 16'h0000, 1'b0, '0, '0, 1'b0, 1'b0);
    // Allocate, hit, then drain the counter to strongly not-taken.
    applyStimulus(1'b0, '0, 1'b1, 16'h1234, 16'hABCD, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h1234, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 16'h1234, 16'h0BAD, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h1234, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(1);

    applyReset();
    // Fill, then overflow into entry 0 via the pointer.
    for (int i = 1; i <= 5; i++) applyStimulus(1'b0, '0, 1'b1, 16'(i * 16), 16'(16'h100 + i), 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0010, 1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0050, 1'b0, '0, '0, 1'b0, 1'b0);
    // Next overflow must evict entry 1 (tag 0x20).
    applyStimulus(1'b1, 16'h0020, 1'b1, 16'h1234, 16'hABCD, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0020, 1'b0, '0, '0, 1'b0, 1'b0);
    // Same-cycle read and update: read sees old target.
    applyStimulus(1'b1, 16'h1234, 1'b1, 16'h1234, 16'h5555, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h1234, 1'b0, '0, '0, 1'b0, 1'b0);
    // Invalidate wins over update; read in the same cycle sees pre-invalidate data.
    applyStimulus(1'b1, 16'h0030, 1'b1, 16'h0060, 16'h6666, 1'b1, 1'b1);
    applyStimulus(1'b1, 16'h0060, 1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h1234, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 16'(i * 16), 1'b1, 16'(16'h700 + i), 16'(i), 1'b1, 1'b0);
    idle(1);

    for (int i = 0; i < 6; i++) pool[i] = 16'($urandom);
    for (int n = 0; n < 500; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, pool[$urandom_range(0, 5)],
                    $urandom_range(0, 1) == 1, pool[$urandom_range(0, 5)], 16'($urandom),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
      if (n == 250) applyReset();
    end
    idle(2);

    for (int i = 0; i < 10 && (rd_q.size() > 0 || uh_q.size() > 0); i++) @(posedge btb_entry_clk);
    if (rd_q.size() > 0 || uh_q.size() > 0) begin
      n_compared++;
      n_mismatch++;
      $display("[TB] FAIL drain: %0d read and %0d hit responses still pending, expected 0", rd_q.size(), uh_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
